// File: rtl/lag_bcd_encoder_pkg.sv
// Shared constants, state enum and field formatting for lag_bcd_encoder.
// LAG_BCD_LEADING_BLANK_EN turns leading zero digits into blank glyphs.
package lag_bcd_encoder_pkg;

   localparam int LAG_BIN_WIDTH = 17;
   localparam logic [19:0] MAX_BCDCOUNT = 20'hFFFFF;
   localparam logic [3:0] BLANK_DIGIT = 4'hA;

   localparam int BCD_CUR_LSB = 0;
   localparam int BCD_MIN_LSB = 20;
   localparam int BCD_MAX_LSB = 40;
   localparam int BCD_AVG_LSB = 60;
   localparam int FIELD_MAX = 1;

   localparam logic [79:0] RESET_BCDCOUNT =
      (80'(MAX_BCDCOUNT) << BCD_AVG_LSB) |
      (80'(20'h00000) << BCD_MAX_LSB) |
      (80'(MAX_BCDCOUNT) << BCD_MIN_LSB) |
      (80'(MAX_BCDCOUNT) << BCD_CUR_LSB);

`ifdef LAG_BCD_LEADING_BLANK_EN
   localparam bit LEAD_BLANK = 1'b1;
`else
   localparam bit LEAD_BLANK = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE,
      S_COMMIT
   } lag_state_t;

   // Sentinel for invalid fields, clamp above 99999, optional blanking.
   function automatic logic [19:0] fmt_field(
      input logic [23:0] acc,
      input logic vld,
      input logic is_max
   );
      logic [19:0] r;
      logic lead;
      r = acc[19:0];
      lead = 1'b1;
      if (!vld) begin
         r = is_max ? 20'h00000 : MAX_BCDCOUNT;
      end else if (acc[23:20] != 4'd0) begin
         r = 20'h99999;
      end else if (LEAD_BLANK) begin
         for (int d = 4; d >= 1; d--) begin
            if (lead && r[d*4 +: 4] == 4'd0)
               r[d*4 +: 4] = BLANK_DIGIT;
            else
               lead = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lag_bcd_encoder_step.sv
// One double-dabble iteration: add-3 adjust every digit >= 5,
// then shift the next binary bit into the LSB.
module bcd_dabble_step (
   input  logic [23:0] acc,
   input  logic        bin_bit,
   output logic [23:0] acc_next
);

   logic [23:0] adj;

   always_comb begin
      adj = acc;
      for (int d = 0; d < 6; d++) begin
         if (acc[d*4 +: 4] >= 4'd5)
            adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      acc_next = (adj << 1) | {23'd0, bin_bit};
   end

endmodule

// File: rtl/lag_bcd_encoder.sv
// Sequential binary-to-BCD converter for the four lag statistics.
// Optional build macro: LAG_BCD_LEADING_BLANK_EN.
module lag_bcd_encoder
   import lag_bcd_encoder_pkg::*;
#(
   parameter int BIN_WIDTH = LAG_BIN_WIDTH,
   parameter int NUM_FIELDS = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [BIN_WIDTH-1:0]         bin_cur,
   input  logic [BIN_WIDTH-1:0]         bin_min,
   input  logic [BIN_WIDTH-1:0]         bin_max,
   input  logic [BIN_WIDTH-1:0]         bin_avg,
   input  logic [NUM_FIELDS-1:0]        valid,
   output logic                         busy,
   output logic                         done,
   output logic [NUM_FIELDS*20-1:0]     bcdcount
);

   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam int FW = $clog2(NUM_FIELDS);

   lag_state_t state, state_nx;

   logic [BIN_WIDTH-1:0]    shadow [NUM_FIELDS];
   logic [NUM_FIELDS-1:0]   vld_sh;
   logic [FW-1:0]           f;
   logic [BIN_WIDTH-1:0]    sh;
   logic [23:0]             acc;
   logic [23:0]             acc_step;
   logic [CW-1:0]           cnt;
   logic [NUM_FIELDS*20-1:0] staging;
   logic                    last_field;
   logic                    last_bit;

   assign last_field = (f == FW'(NUM_FIELDS - 1));
   assign last_bit = (cnt == CW'(1));
   assign busy = (state != S_IDLE);

   bcd_dabble_step u_step (
      .acc      (acc),
      .bin_bit  (sh[BIN_WIDTH-1]),
      .acc_next (acc_step)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (start) state_nx = S_LOAD;
         S_LOAD:   state_nx = S_SHIFT;
         S_SHIFT:  if (last_bit) state_nx = S_STORE;
         S_STORE:  state_nx = last_field ? S_COMMIT : S_LOAD;
         S_COMMIT: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Datapath; bcdcount only moves on the COMMIT edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_FIELDS; i++)
            shadow[i] <= '0;
         vld_sh   <= '0;
         f        <= '0;
         sh       <= '0;
         acc      <= '0;
         cnt      <= '0;
         staging  <= RESET_BCDCOUNT;
         bcdcount <= RESET_BCDCOUNT;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  shadow[0] <= bin_cur;
                  shadow[1] <= bin_min;
                  shadow[2] <= bin_max;
                  shadow[3] <= bin_avg;
                  vld_sh    <= valid;
                  f         <= '0;
               end
            end
            S_LOAD: begin
               sh  <= shadow[f];
               acc <= '0;
               cnt <= CW'(BIN_WIDTH);
            end
            S_SHIFT: begin
               acc <= acc_step;
               sh  <= sh << 1;
               cnt <= cnt - CW'(1);
            end
            S_STORE: begin
               staging[f*20 +: 20] <= fmt_field(
                  acc, vld_sh[f], f == FW'(FIELD_MAX + 1));
               if (!last_field)
                  f <= f + FW'(1);
            end
            S_COMMIT: begin
               bcdcount <= staging;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lag_bcd_encoder.sv
// Self-checking bench for lag_bcd_encoder with a decimal reference model.
// Honours LAG_BCD_LEADING_BLANK_EN when defined for the build.
module tb_lag_bcd_encoder;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [16:0] bin_cur;
   logic [16:0] bin_min;
   logic [16:0] bin_max;
   logic [16:0] bin_avg;
   logic [3:0]  valid;
   logic        busy;
   logic        done;
   logic [79:0] bcdcount;

   int checks = 0;
   int failures = 0;
   logic [79:0] exp_prev;

   localparam logic [79:0] RST_VAL = 80'hFFFFF_00000_FFFFF_FFFFF;

   lag_bcd_encoder dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .bin_cur  (bin_cur),
      .bin_min  (bin_min),
      .bin_max  (bin_max),
      .bin_avg  (bin_avg),
      .valid    (valid),
      .busy     (busy),
      .done     (done),
      .bcdcount (bcdcount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [19:0] m_field(int v, bit vld, bit is_max);
      logic [19:0] r;
      int p;
      if (!vld) return is_max ? 20'h00000 : 20'hFFFFF;
      if (v > 99999) return 20'h99999;
      r = '0;
      p = 1;
      for (int d = 0; d < 5; d++) begin
         r[d*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
`ifdef LAG_BCD_LEADING_BLANK_EN
      p = 10;
      for (int d = 1; d < 5; d++) begin
         if (v < p) r[d*4 +: 4] = 4'hA;
         p = p * 10;
      end
`endif
      return r;
   endfunction

   function automatic logic [79:0] model(int c, int mn, int mx, int av,
                                         logic [3:0] vl);
      return {m_field(av, vl[3], 0), m_field(mx, vl[2], 1),
              m_field(mn, vl[1], 0), m_field(c, vl[0], 0)};
   endfunction

   function automatic int rv();
      case ($urandom_range(0, 3))
         0: return int'($urandom_range(0, 9));
         1: return int'($urandom_range(0, 999));
         2: return int'($urandom_range(0, 99999));
         default: return int'($urandom_range(0, 131071));
      endcase
   endfunction

   task automatic chk80(string tag, logic [79:0] obs, logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkint(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_conv(input int c, input int mn, input int mx,
                          input int av, input logic [3:0] vl,
                          input bit disturb, output logic [79:0] got);
      logic [79:0] exp;
      int dones;
      exp = model(c, mn, mx, av, vl);
      dones = 0;
      got = '0;
      @(negedge clock);
      bin_cur = 17'(c);
      bin_min = 17'(mn);
      bin_max = 17'(mx);
      bin_avg = 17'(av);
      valid = vl;
      start = 1'b1;
      for (int k = 1; k <= 79; k++) begin
         @(negedge clock);
         if (done === 1'b1) dones++;
         if (k == 1) chk1("busy_c1", busy, 1'b1);
         if (k == 77) begin
            chk1("busy_c77", busy, 1'b1);
            chk80("hold_c77", bcdcount, exp_prev);
         end
         if (k == 78) begin
            chk1("busy_c78", busy, 1'b0);
            chk1("done_c78", done, 1'b1);
            chk80("result", bcdcount, exp);
            got = bcdcount;
         end
         start = 1'b0;
         if (disturb && k == 10) begin
            bin_cur = 17'($urandom);
            bin_min = 17'($urandom);
            bin_max = 17'($urandom);
            bin_avg = 17'($urandom);
            valid = 4'($urandom);
         end
         if (disturb && k == 40) start = 1'b1;
      end
      chkint("done_count", dones, 1);
      exp_prev = exp;
   endtask

   initial begin
      logic [79:0] got;
      reset_n = 1'b0;
      start = 1'b0;
      bin_cur = '0;
      bin_min = '0;
      bin_max = '0;
      bin_avg = '0;
      valid = '0;
      exp_prev = RST_VAL;
      repeat (3) @(negedge clock);
      chk80("rst_bcd", bcdcount, RST_VAL);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      chk80("idle_bcd", bcdcount, RST_VAL);
      chk1("idle_busy", busy, 1'b0);

      do_conv(12345, 7, 99999, 500, 4'hF, 1'b0, got);
`ifdef LAG_BCD_LEADING_BLANK_EN
      chk80("plan_vec", got, 80'hAA500_99999_AAAA7_12345);
`else
      chk80("plan_vec", got, 80'h00500_99999_00007_12345);
`endif

      do_conv(131071, 3, 4, 5, 4'h1, 1'b0, got);
      chk80("overflow", got, 80'hFFFFF_00000_FFFFF_99999);

      do_conv(0, 0, 0, 0, 4'h1, 1'b0, got);
`ifdef LAG_BCD_LEADING_BLANK_EN
      chk80("zero_cur", got, 80'hFFFFF_00000_FFFFF_AAAA0);
`else
      chk80("zero_cur", got, 80'hFFFFF_00000_FFFFF_00000);
`endif

      do_conv(54321, 100000, 10, 99999, 4'hE, 1'b1, got);

      @(negedge clock);
      bin_cur = 17'd777;
      valid = 4'hF;
      start = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clock);
         start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      chk80("abort_bcd", bcdcount, RST_VAL);
      @(negedge clock);
      reset_n = 1'b1;
      exp_prev = RST_VAL;

      do_conv(98765, 1, 65535, 4321, 4'hF, 1'b0, got);

      for (int i = 0; i < 8; i++) begin
         do_conv(rv(), rv(), rv(), rv(), 4'($urandom),
                 1'($urandom), got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
